// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA request arbiter.
package dma_pkg;

  // Channel count; the arbiter and encoder are built for exactly four channels.
  localparam int NUM_CH = 4;

  typedef logic [1:0] ch_idx_t;

  // Bus-hold sequencer states: idle, hold requested, channel granted, bus release.
  typedef enum logic [1:0] {
    SI,
    S_REQ,
    S_ACK,
    S_REL
  } arb_state_t;

  // One-hot decode of a channel index.
  function automatic logic [NUM_CH-1:0] ch_onehot(input ch_idx_t idx);
    logic [NUM_CH-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/dma_prio_encoder.sv
// Rotating priority encoder: scans req starting at 'start' and wrapping,
// returning the first requesting channel. start = 0 gives fixed priority.
module dma_prio_encoder
  import dma_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  ch_idx_t           start,
  output ch_idx_t           winner,
  output logic              valid
);

  // Walk from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves it unassigned (no latch).
    winner = start;
    valid  = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[ch_idx_t'(start + ch_idx_t'(i))]) begin
        winner = ch_idx_t'(start + ch_idx_t'(i));
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// Four-channel DMA request arbiter with CPU bus-hold handshake, fixed or
// rotating priority, single-transfer grants and sticky terminal-count flags.
module dma_priority_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] chMask,
  input  logic              rotatePri,
  input  logic              HLDA,
  input  logic              xferDone,
  input  logic              tc,
  input  logic              statusRead,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output ch_idx_t           activeCh,
  output logic [NUM_CH-1:0] tcStatus
);

  arb_state_t        state;
  ch_idx_t           top_pri;
  ch_idx_t           start_idx;
  ch_idx_t           win;
  logic              win_valid;
  logic [NUM_CH-1:0] req;
  logic              xfer_end;
  logic [NUM_CH-1:0] tc_next;

  // Masked requests; a request masked in the same cycle it appears never counts.
  assign req       = DREQ & ~chMask;
  // Rotation pointer is always maintained but only steers arbitration in rotating mode.
  assign start_idx = rotatePri ? top_pri : ch_idx_t'(0);
  // Completion only counts while a channel actually holds the grant.
  assign xfer_end  = (state == S_ACK) && xferDone;

  dma_prio_encoder u_prio_encoder (
    .req    (req),
    .start  (start_idx),
    .winner (win),
    .valid  (win_valid)
  );

  // Hold-handshake FSM with registered HRQ/DACK/activeCh and the rotation pointer.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    if (RESET) begin
      state    <= SI;
      HRQ      <= 1'b0;
      DACK     <= '0;
      activeCh <= '0;
      top_pri  <= '0;
    end else begin
      case (state)
        SI: begin
          if (win_valid) begin
            state <= S_REQ;
            HRQ   <= 1'b1;
          end
        end
        S_REQ: begin
          if (!win_valid) begin
            state <= SI;
            HRQ   <= 1'b0;
          end else if (HLDA) begin
            state    <= S_ACK;
            activeCh <= win;
            DACK     <= ch_onehot(win);
          end
        end
        S_ACK: begin
          if (xferDone) begin
            state   <= S_REL;
            HRQ     <= 1'b0;
            DACK    <= '0;
            top_pri <= ch_idx_t'(activeCh + ch_idx_t'(1));
          end
        end
        S_REL: begin
          if (!HLDA) begin
            state <= SI;
          end
        end
        default: begin
          state <= SI;
          HRQ   <= 1'b0;
          DACK  <= '0;
        end
      endcase
    end
  end

  // Next terminal-count flags: a read clears everything, a same-cycle TC set still wins for its channel.
  always_comb begin
    tc_next = statusRead ? '0 : tcStatus;
    if (xfer_end && tc) begin
      tc_next[activeCh] = 1'b1;
    end
  end

  // Sticky terminal-count status register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tcStatus <= '0;
    end else begin
      tcStatus <= tc_next;
    end
  end

  // Grant sanity: at most one acknowledge, and only while the bus is held.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      assert ($onehot0(DACK))
        else $error("DACK not one-hot");
      assert ((DACK == '0) || HRQ)
        else $error("DACK without HRQ");
    end
  end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Randomized self-checking bench for dma_priority_arbiter against a
// transaction-level model of priority selection and terminal-count status.
module tb_dma_priority_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] DREQ;
  logic [3:0] chMask;
  logic       rotatePri;
  logic       HLDA;
  logic       xferDone;
  logic       tc;
  logic       statusRead;
  logic       HRQ;
  logic [3:0] DACK;
  logic [1:0] activeCh;
  logic [3:0] tcStatus;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: rotation start channel and sticky TC flags.
  int         exp_top = 0;
  logic [3:0] exp_tc  = '0;

  dma_priority_arbiter #(.NUM_CH(4)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .DREQ       (DREQ),
    .chMask     (chMask),
    .rotatePri  (rotatePri),
    .HLDA       (HLDA),
    .xferDone   (xferDone),
    .tc         (tc),
    .statusRead (statusRead),
    .HRQ        (HRQ),
    .DACK       (DACK),
    .activeCh   (activeCh),
    .tcStatus   (tcStatus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // First requesting channel scanning upward from 'start' with wrap; -1 if none.
  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  // One complete single-transfer transaction starting from idle.
  task automatic grant(input logic [3:0] dreq, input logic [3:0] mask, input logic rot,
                       input int hlda_wait, input int ack_cycles,
                       input logic tc_bit, input logic sr, output int got);
    logic [3:0] r;
    int         w;
    r   = dreq & ~mask;
    got = -1;
    DREQ = dreq; chMask = mask; rotatePri = rot;
    tick();
    check("hrq_rise", {31'b0, HRQ}, {31'b0, (r != 4'b0)});
    if (r == 4'b0) return;
    for (int i = 0; i < hlda_wait; i++) begin
      check("wait_dack", {28'b0, DACK}, 32'h0);
      tick();
    end
    HLDA = 1'b1;
    w = pick(r, rot ? exp_top : 0);
    tick();
    got = int'(activeCh);
    check("grant_dack", {28'b0, DACK}, 32'(1) << w);
    check("grant_ch", {30'b0, activeCh}, w);
    check("grant_hrq", {31'b0, HRQ}, 32'h1);
    for (int i = 0; i < ack_cycles; i++) begin
      DREQ = 4'($urandom); chMask = 4'($urandom); rotatePri = 1'($urandom);
      tick();
      check("ack_hold", {28'b0, DACK}, 32'(1) << w);
    end
    xferDone = 1'b1; tc = tc_bit; statusRead = sr;
    tick();
    if (sr) exp_tc = '0;
    if (tc_bit) exp_tc[w] = 1'b1;
    exp_top = (w + 1) % 4;
    xferDone = 1'b0; tc = 1'b0; statusRead = 1'b0; DREQ = '0; chMask = '0;
    check("rel_dack", {28'b0, DACK}, 32'h0);
    check("rel_hrq", {31'b0, HRQ}, 32'h0);
    check("tc_status", {28'b0, tcStatus}, {28'b0, exp_tc});
    tick();
    check("rel_hold", {31'b0, HRQ}, 32'h0);
    HLDA = 1'b0;
    tick();
    check("idle_hrq", {31'b0, HRQ}, 32'h0);
  endtask

  initial begin
    int got;
    RESET = 1'b1; DREQ = '0; chMask = '0; rotatePri = 1'b0; HLDA = 1'b0;
    xferDone = 1'b0; tc = 1'b0; statusRead = 1'b0;
    tick(); tick();
    check("rst_hrq", {31'b0, HRQ}, 32'h0);
    check("rst_dack", {28'b0, DACK}, 32'h0);
    check("rst_ch", {30'b0, activeCh}, 32'h0);
    check("rst_tc", {28'b0, tcStatus}, 32'h0);
    RESET = 1'b0;

    // HLDA alone in idle does nothing.
    HLDA = 1'b1;
    tick(); tick();
    check("hlda_idle", {31'b0, HRQ}, 32'h0);
    HLDA = 1'b0;
    tick();

    // Fixed priority: 1010 goes to ch1.
    grant(4'b1010, 4'b0000, 1'b0, 0, 0, 1'b0, 1'b0, got);
    check("fixed_ch1", got, 1);

    // Rotation: pointer is now 2 after the ch1 transfer; reset it via a ch3 grant.
    grant(4'b1000, 4'b0000, 1'b0, 1, 1, 1'b0, 1'b0, got);
    check("fixed_ch3", got, 3);
    grant(4'b1111, 4'b0000, 1'b1, 0, 0, 1'b0, 1'b0, got);
    check("rot_wrap0", got, 0);
    grant(4'b1111, 4'b0000, 1'b1, 0, 2, 1'b0, 1'b0, got);
    check("rot_g1", got, 1);
    grant(4'b1111, 4'b0000, 1'b1, 2, 0, 1'b0, 1'b0, got);
    check("rot_g2", got, 2);
    grant(4'b1000, 4'b0000, 1'b1, 0, 0, 1'b0, 1'b0, got);
    check("rot_g3", got, 3);
    grant(4'b0001, 4'b0000, 1'b1, 0, 0, 1'b0, 1'b0, got);
    check("rot_wrap", got, 0);

    // Masking: ch0 masked, ch1 wins even in fixed mode.
    grant(4'b0011, 4'b0001, 1'b0, 0, 0, 1'b0, 1'b0, got);
    check("mask_ch1", got, 1);

    // Request withdrawn before HLDA: HRQ drops, no grant ever.
    DREQ = 4'b0011; chMask = 4'b0001; rotatePri = 1'b0;
    tick();
    check("drop_hrq_up", {31'b0, HRQ}, 32'h1);
    DREQ = 4'b0001;
    tick();
    check("drop_hrq_dn", {31'b0, HRQ}, 32'h0);
    HLDA = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("drop_nodack", {28'b0, DACK}, 32'h0);
      check("drop_nohrq", {31'b0, HRQ}, 32'h0);
    end
    HLDA = 1'b0; DREQ = '0; chMask = '0;
    tick();

    // xferDone with tc outside a grant is ignored.
    xferDone = 1'b1; tc = 1'b1;
    tick();
    xferDone = 1'b0; tc = 1'b0;
    check("idle_xfer_tc", {28'b0, tcStatus}, {28'b0, exp_tc});

    // Terminal-count status: set ch2, then read colliding with TC on ch3.
    grant(4'b0100, 4'b0000, 1'b0, 0, 0, 1'b1, 1'b0, got);
    check("tc_ch2", {28'b0, tcStatus}, 32'h4);
    grant(4'b1000, 4'b0000, 1'b0, 0, 0, 1'b1, 1'b1, got);
    check("tc_ch3_rd", {28'b0, tcStatus}, 32'h8);

    // Minimum gap: a held request re-raises HRQ two edges after HLDA falls.
    DREQ = 4'b0010; rotatePri = 1'b0;
    tick();
    HLDA = 1'b1;
    tick();
    xferDone = 1'b1;
    tick();
    xferDone = 1'b0;
    exp_top = 2;
    HLDA = 1'b0;
    tick();
    check("gap_si", {31'b0, HRQ}, 32'h0);
    tick();
    check("gap_hrq", {31'b0, HRQ}, 32'h1);
    DREQ = '0;
    tick();
    check("gap_drop", {31'b0, HRQ}, 32'h0);

    // Reset mid-grant in rotating mode.
    DREQ = 4'b1111; rotatePri = 1'b1;
    tick();
    HLDA = 1'b1;
    tick();
    check("pre_rst_ch", {30'b0, activeCh}, exp_top);
    RESET = 1'b1;
    tick();
    check("mrst_dack", {28'b0, DACK}, 32'h0);
    check("mrst_hrq", {31'b0, HRQ}, 32'h0);
    check("mrst_tc", {28'b0, tcStatus}, 32'h0);
    RESET = 1'b0; HLDA = 1'b0; DREQ = '0;
    exp_top = 0; exp_tc = '0;
    tick();
    grant(4'b1111, 4'b0000, 1'b1, 0, 0, 1'b0, 1'b0, got);
    check("mrst_rot0", got, 0);

    // Randomized transactions.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        xferDone = 1'b1; tc = 1'b1;
        tick();
        xferDone = 1'b0; tc = 1'b0;
        check("rnd_idle_tc", {28'b0, tcStatus}, {28'b0, exp_tc});
      end
      grant(4'($urandom), 4'($urandom_range(0, 15) & 4'($urandom)), 1'($urandom),
            $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom), got);
      DREQ = '0; chMask = '0;
      tick();
      check("rnd_idle", {31'b0, HRQ}, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_priority_arbiter.md
# dma_priority_arbiter

Four-channel DMA request arbiter and bus-hold sequencer for the DMA controller. It samples channel requests `DREQ[3:0]`, applies the channel mask, and selects one channel by fixed or rotating priority. It obtains the bus from the CPU through an `HRQ`/`HLDA` hold handshake, asserts the one-hot `DACK` for the winner until the transfer datapath reports completion, then releases the bus. It sits between the channel request pins and the address/count datapath, and keeps sticky per-channel terminal-count status.

## Interface
Parameters:
- `NUM_CH`, 4: number of channels. Only 4 is supported; the width of `activeCh` derives from it.

Ports:
- `CLK`, in, 1: single clock; all logic is on the rising edge.
- `RESET`, in, 1: synchronous, active-high reset.
- `DREQ`, in, NUM_CH: channel requests, active-high level.
- `chMask`, in, NUM_CH: 1 means the channel is masked (its request is ignored).
- `rotatePri`, in, 1: 0 = fixed priority (ch0 highest); 1 = rotating priority.
- `HLDA`, in, 1: hold acknowledge from the CPU.
- `xferDone`, in, 1: one-cycle pulse from the datapath marking the end of the current transfer.
- `tc`, in, 1: terminal count; only meaningful when `xferDone` = 1.
- `statusRead`, in, 1: one-cycle pulse that clears `tcStatus`.
- `HRQ`, out, 1: hold request to the CPU.
- `DACK`, out, NUM_CH: one-hot acknowledge to the granted channel.
- `activeCh`, out, 2: index of the granted channel.
- `tcStatus`, out, NUM_CH: sticky terminal-count flags, one per channel.

## Operation
- Effective request vector: `req = DREQ & ~chMask`.
- The FSM has four states: `SI` (idle), `S_REQ` (HRQ raised, waiting for HLDA), `S_ACK` (channel granted), `S_REL` (bus release).
- `SI`:
  - if `req != 0`, go to `S_REQ`;
  - `HRQ` = 0, `DACK` = 0.
- `S_REQ`:
  - `HRQ` = 1;
  - if `req == 0` (requests dropped or masked), return to `SI`;
  - else if `HLDA` = 1, arbitrate on the `req` of that cycle, latch the winner into `activeCh`, and go to `S_ACK`.
- `S_ACK`:
  - `HRQ` = 1 and `DACK` = one-hot of `activeCh`;
  - changes to `DREQ` or `chMask` are ignored;
  - on `xferDone`, go to `S_REL`.
- `S_REL`:
  - `HRQ` = 0, `DACK` = 0;
  - when `HLDA` = 0, go to `SI`.
- Each grant covers exactly one transfer (single-transfer mode).
- Priority:
  - Fixed mode: channel 0 is highest and channel 3 is lowest.
  - Rotating mode: the highest-priority channel is given by pointer `topPri`.
  - On every `xferDone`, `topPri` becomes `(activeCh + 1) mod 4`; the wrap from 3 to 0 is required.
  - `topPri` updates in both modes but is used only when `rotatePri` = 1.
  - A change of `rotatePri` takes effect at the next arbitration.
- Terminal-count status:
  - `xferDone & tc` sets `tcStatus[activeCh]`.
  - `statusRead` clears all bits.
  - If both occur in the same cycle, the set wins for `activeCh` and all other bits clear.

## Timing
- Reset values: `HRQ` = 0, `DACK` = 0, `activeCh` = 0, `tcStatus` = 0, `topPri` = 0, state = `SI`.
- A `RESET` asserted mid-grant forces all of the above on the next edge; `DACK` drops even while `HLDA` is still high.
- Latency from request to hold: `req` becomes nonzero in `SI` at cycle N, and `HRQ` = 1 at N+1.
- Latency from hold acknowledge to grant: `HLDA` is sampled at 1 in `S_REQ` at cycle K, and `DACK`/`activeCh` are valid at K+1.
- Release: `xferDone` at cycle M makes `DACK` = 0 and `HRQ` = 0 at M+1.
- Minimum gap: after `HLDA` returns to 0 in `S_REL`, the block is in `SI` at the next edge, so a new `HRQ` appears no sooner than 2 cycles after `HLDA` falls.
- A request that appears and is masked in the same cycle is never seen.
- `xferDone` outside `S_ACK` is ignored; it does not change `tcStatus` or `topPri`.
- `HLDA` = 1 while in `SI` is ignored; `HRQ` stays 0 until a request exists.
- Invariants:
  - `DACK` is one-hot or zero.
  - `DACK != 0` implies `HRQ` = 1 and `HLDA` was high on the grant cycle.

## Structure
- Package `dma_pkg` holds:
  - `NUM_CH`;
  - `ch_idx_t` (logic [1:0]);
  - the `arb_state_t` enum {SI, S_REQ, S_ACK, S_REL}.
- Sub-module `dma_prio_encoder`: a combinational rotating priority encoder. Its inputs are `req` and the start index (`topPri`, or 0 in fixed mode); its outputs are the winner index and a valid flag.
- The top level contains the FSM, the `activeCh`/`topPri` registers, and the `tcStatus` register.

## Test plan
- Fixed priority:
  - Stimulus: `DREQ` = 4'b1010, mask 0, `rotatePri` = 0, `HLDA` returned one cycle after `HRQ`.
  - Required response: `HRQ` rises 1 cycle after `DREQ`; `DACK` = 4'b0010 and `activeCh` = 1 one cycle after `HLDA`.
- Rotation:
  - Stimulus: `rotatePri` = 1, `DREQ` = 4'b1111 held, three transfers.
  - Required response: grants go to ch0, ch1, then ch2.
  - Follow-on stimulus: from ch3, the next grant with `DREQ` = 4'b0001 goes to ch0 (wrap check).
- Masking:
  - Stimulus: `chMask` = 4'b0001 with `DREQ` = 4'b0011.
  - Required response: ch1 is granted.
  - Follow-on stimulus: in `S_REQ`, before `HLDA`, drop `DREQ` to 4'b0001.
  - Required response: `HRQ` falls next cycle; no `DACK` is ever asserted.
- Terminal-count status:
  - Stimulus: `xferDone` + `tc` on ch2, then `statusRead` in the same cycle as a TC on ch3.
  - Required response: `tcStatus` = 4'b0100, then 4'b1000.
- Reset mid-grant:
  - Stimulus: assert `RESET` in `S_ACK` while `HLDA` = 1.
  - Required response: on the next edge, `DACK` = 0, `HRQ` = 0, `tcStatus` = 0, and the next arbitration in rotating mode starts at ch0.
